// File: rtl/fpu_fclass_vecgen_pkg.sv
// Shared constants for the fclass vector generator: class bit indices and
// default half-precision field geometry.
package fpu_fclass_vecgen_pkg;

   localparam int FCLASS_STD = 15;
   localparam int FCLASS_MAN = 9;
   localparam int EXP_W      = FCLASS_STD - FCLASS_MAN - 1;
   localparam int MAN_W      = FCLASS_MAN + 1;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   localparam int NUM_CLS = 10;

   localparam logic [3:0] CLS_NEG_INF  = 4'd0;
   localparam logic [3:0] CLS_NEG_NORM = 4'd1;
   localparam logic [3:0] CLS_NEG_SUB  = 4'd2;
   localparam logic [3:0] CLS_NEG_ZERO = 4'd3;
   localparam logic [3:0] CLS_POS_ZERO = 4'd4;
   localparam logic [3:0] CLS_POS_SUB  = 4'd5;
   localparam logic [3:0] CLS_POS_NORM = 4'd6;
   localparam logic [3:0] CLS_POS_INF  = 4'd7;
   localparam logic [3:0] CLS_SNAN     = 4'd8;
   localparam logic [3:0] CLS_QNAN     = 4'd9;

   typedef logic [NUM_CLS-1:0] cls_mask_t;

endpackage

// File: rtl/fpu_class_value.sv
// Combinational map from a class index and a seed to an operand that
// classifies back to that class.
module fpu_class_value
   import fpu_fclass_vecgen_pkg::*;
#(
   parameter int Std = EXP_W + MAN_W,
   parameter int Man = MAN_W - 1
) (
   input  logic [3:0]   cls,
   input  logic [Std:0] seed,
   output logic [Std:0] operand
);

   localparam int ExpW  = Std - Man - 1;
   localparam int MantW = Man + 1;

   logic [ExpW-1:0]  s_exp;
   logic [ExpW-1:0]  exp_max;
   logic [ExpW-1:0]  norm_exp;
   logic [Man:0]     s_man;
   logic [Man:0]     sub_man;
   logic [Man:0]     snan_man;
   logic             sign;
   logic [ExpW-1:0]  e;
   logic [Man:0]     m;
   logic             unused_seed_sign;

   assign s_exp            = seed[Std-1:Man+1];
   assign s_man            = seed[Man:0];
   assign exp_max          = '1;
   assign unused_seed_sign = seed[Std];

   // Seed fields are nudged off the values that would change the class.
   assign norm_exp = (s_exp == '0)     ? ExpW'(1)
                   : (s_exp == exp_max) ? exp_max - ExpW'(1)
                   :                      s_exp;
   assign sub_man  = (s_man == '0) ? MantW'(1) : s_man;
   assign snan_man = {1'b0, (s_man[Man-1:0] == '0) ? Man'(1) : s_man[Man-1:0]};

   // NOTE: every output of an always_comb gets a default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      sign = 1'b0;
      e    = '0;
      m    = '0;
      case (cls)
         CLS_NEG_INF:  begin sign = 1'b1; e = exp_max; end
         CLS_NEG_NORM: begin sign = 1'b1; e = norm_exp; m = s_man; end
         CLS_NEG_SUB:  begin sign = 1'b1; m = sub_man; end
         CLS_NEG_ZERO: sign = 1'b1;
         CLS_POS_ZERO: sign = 1'b0;
         CLS_POS_SUB:  m = sub_man;
         CLS_POS_NORM: begin e = norm_exp; m = s_man; end
         CLS_POS_INF:  e = exp_max;
         CLS_SNAN:     begin e = exp_max; m = snan_man; end
         CLS_QNAN:     begin e = exp_max; m = {1'b1, {Man{1'b0}}}; end
         default:      ;
      endcase
   end

   assign operand = {sign, e, m};

endmodule

// File: rtl/fpu_fclass_vecgen.sv
// Turns an fclass-format mask into a stream of representative operands,
// one per set class bit, lowest bit first.
module fpu_fclass_vecgen
   import fpu_fclass_vecgen_pkg::*;
#(
   parameter int Std = EXP_W + MAN_W,
   parameter int Man = MAN_W - 1
) (
   input  logic         clk,
   input  logic         rst_l,
   input  logic         flush,
   input  logic         cls_valid,
   output logic         cls_ready,
   input  logic [31:0]  cls_mask,
   input  logic [Std:0] seed,
   output logic         vec_valid,
   input  logic         vec_ready,
   output logic [Std:0] vec_data,
   output logic [3:0]   vec_class,
   output logic         vec_last,
   output logic         empty_err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [0:0]   state;
   cls_mask_t    rem_mask;
   logic [Std:0] seed_q;
   logic         empty_err_q;
   logic [3:0]   low_idx;
   logic         one_left;
   logic         emitting;
   logic [Std:0] cls_value;
   logic         unused_mask_hi;

   assign unused_mask_hi = ^cls_mask[31:NUM_CLS];

   always_comb begin
      low_idx = '0;
      for (int i = NUM_CLS - 1; i >= 0; i--) begin
         if (rem_mask[i]) low_idx = 4'(i);
      end
   end

   assign one_left = (rem_mask != '0) && ((rem_mask & (rem_mask - cls_mask_t'(1))) == '0);
   assign emitting = (state == ST_EMIT);

   fpu_class_value #(
      .Std (Std),
      .Man (Man)
   ) u_value (
      .cls     (low_idx),
      .seed    (seed_q),
      .operand (cls_value)
   );

   // NOTE: state registers use non-blocking assignments so every flop in the
   // block samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state       <= ST_IDLE;
         rem_mask    <= '0;
         seed_q      <= '0;
         empty_err_q <= 1'b0;
      end else if (flush) begin
         state       <= ST_IDLE;
         rem_mask    <= '0;
         empty_err_q <= 1'b0;
      end else begin
         empty_err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cls_valid) begin
                  if (cls_mask[NUM_CLS-1:0] != '0) begin
                     rem_mask <= cls_mask[NUM_CLS-1:0];
                     seed_q   <= seed;
                     state    <= ST_EMIT;
                  end else begin
                     empty_err_q <= 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               if (vec_ready) begin
                  rem_mask <= rem_mask & (rem_mask - cls_mask_t'(1));
                  if (one_left) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are gated by the registered state so they read zero while idle.
   assign cls_ready = (state == ST_IDLE);
   assign vec_valid = emitting;
   assign vec_class = emitting ? low_idx : 4'd0;
   assign vec_last  = emitting & one_left;
   assign vec_data  = emitting ? cls_value : '0;
   assign empty_err = empty_err_q;

endmodule

// File: tb/tb_fpu_fclass_vecgen.sv
// Directed bench for fpu_fclass_vecgen: expected beats are queued as masks
// are offered and compared on the falling edge as the DUT emits them.
module tb_fpu_fclass_vecgen;
   import fpu_fclass_vecgen_pkg::*;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  cls;
      logic        last;
   } beat_t;

   logic        clk;
   logic        rst_l;
   logic        flush;
   logic        cls_valid;
   logic        cls_ready;
   logic [31:0] cls_mask;
   logic [15:0] seed;
   logic        vec_valid;
   logic        vec_ready;
   logic [15:0] vec_data;
   logic [3:0]  vec_class;
   logic        vec_last;
   logic        empty_err;

   beat_t sb_q[$];
   int    checks   = 0;
   int    failures = 0;

   // Expected operand for each class with seed 0x3C01.
   logic [15:0] tbl_3c01 [10] = '{16'hFC00, 16'hBC01, 16'h8001, 16'h8000, 16'h0000,
                                  16'h0001, 16'h3C01, 16'h7C00, 16'h7C01, 16'h7E00};

   fpu_fclass_vecgen dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .flush     (flush),
      .cls_valid (cls_valid),
      .cls_ready (cls_ready),
      .cls_mask  (cls_mask),
      .seed      (seed),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec_data  (vec_data),
      .vec_class (vec_class),
      .vec_last  (vec_last),
      .empty_err (empty_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [3:0] c, input logic l);
      sb_q.push_back('{data: d, cls: c, last: l});
   endtask

   task automatic push_table(input logic [9:0] m);
      for (int i = 0; i < 10; i++) begin
         if (m[i]) push(tbl_3c01[i], 4'(i), (m >> (i + 1)) == 10'd0);
      end
   endtask

   task automatic send_mask(input logic [31:0] m, input logic [15:0] s);
      int budget = 50;
      cls_mask  = m;
      seed      = s;
      cls_valid = 1'b1;
      while (!cls_ready && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("accept_in_time", 32'(budget > 0), 32'd1);
      @(posedge clk); #1;
      cls_valid = 1'b0;
      cls_mask  = '0;
   endtask

   task automatic drain(input string tag);
      int budget = 300;
      while ((sb_q.size() != 0 || !cls_ready) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check({tag, "_all_beats"}, 32'(sb_q.size()), 32'd0);
      check({tag, "_idle"}, 32'(cls_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cls_ready"}, 32'(cls_ready), 32'd1);
      check({tag, "_vec_valid"}, 32'(vec_valid), 32'd0);
      check({tag, "_vec_data"},  32'(vec_data),  32'd0);
      check({tag, "_vec_class"}, 32'(vec_class), 32'd0);
      check({tag, "_vec_last"},  32'(vec_last),  32'd0);
      check({tag, "_empty_err"}, 32'(empty_err), 32'd0);
   endtask

   // Scoreboard: the head entry must be presented until it is accepted.
   always @(negedge clk) begin
      if (rst_l && vec_valid) begin
         if (sb_q.size() == 0) begin
            check("beat_expected", 32'(sb_q.size()), 32'd1);
         end else begin
            check($sformatf("beat_data_c%0d", sb_q[0].cls), 32'(vec_data), 32'(sb_q[0].data));
            check($sformatf("beat_class_c%0d", sb_q[0].cls), 32'(vec_class), 32'(sb_q[0].cls));
            check($sformatf("beat_last_c%0d", sb_q[0].cls), 32'(vec_last), 32'(sb_q[0].last));
            if (vec_ready) void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int budget;
      rst_l     = 1'b0;
      flush     = 1'b0;
      cls_valid = 1'b0;
      cls_mask  = '0;
      seed      = '0;
      vec_ready = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk); #1;

      // -inf and +inf with seed 0, exact cycle timing.
      vec_ready = 1'b1;
      push(16'hFC00, CLS_NEG_INF, 1'b0);
      push(16'h7C00, CLS_POS_INF, 1'b1);
      send_mask(32'h0000_0081, 16'h0000);
      check("t1_busy", 32'(cls_ready), 32'd0);
      check("t1_first_valid", 32'(vec_valid), 32'd1);
      @(posedge clk); #1;
      check("t1_second_valid", 32'(vec_valid), 32'd1);
      @(posedge clk); #1;
      check("t1_ready_back", 32'(cls_ready), 32'd1);
      check("t1_valid_low", 32'(vec_valid), 32'd0);
      check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

      // Zeros and canonical qNaN.
      push(16'h8000, CLS_NEG_ZERO, 1'b0);
      push(16'h0000, CLS_POS_ZERO, 1'b0);
      push(16'h7E00, CLS_QNAN, 1'b1);
      send_mask(32'h0000_0218, 16'h0000);
      drain("t2");

      // Seeded normals, subnormals and sNaN.
      push(16'hBC01, CLS_NEG_NORM, 1'b0);
      push(16'h8001, CLS_NEG_SUB, 1'b0);
      push(16'h0001, CLS_POS_SUB, 1'b0);
      push(16'h3C01, CLS_POS_NORM, 1'b0);
      push(16'h7C01, CLS_SNAN, 1'b1);
      send_mask(32'h0000_0166, 16'h3C01);
      drain("t3");

      // Seed boundaries: all-zero and all-ones fields.
      push(16'h0001, CLS_POS_SUB, 1'b0);
      push(16'h0400, CLS_POS_NORM, 1'b0);
      push(16'h7C01, CLS_SNAN, 1'b1);
      send_mask(32'h0000_0160, 16'h0000);
      drain("t4a");
      push(16'h03FF, CLS_POS_SUB, 1'b0);
      push(16'h7BFF, CLS_POS_NORM, 1'b0);
      push(16'h7DFF, CLS_SNAN, 1'b1);
      send_mask(32'h0000_0160, 16'h7FFF);
      drain("t4b");

      // Every class, consumer stalling at random.
      vec_ready = 1'b0;
      push_table(10'h3FF);
      send_mask(32'h0000_03FF, 16'h3C01);
      budget = 400;
      while (sb_q.size() != 0 && budget > 0) begin
         vec_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         budget--;
      end
      vec_ready = 1'b1;
      drain("t5");

      // Flush while the third beat is presented.
      push_table(10'h3FF);
      send_mask(32'h0000_03FF, 16'h3C01);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush     = 1'b1;
      vec_ready = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      check("t6_valid_low", 32'(vec_valid), 32'd0);
      check("t6_ready_high", 32'(cls_ready), 32'd1);
      check("t6_beats_left", 32'(sb_q.size()), 32'd8);
      sb_q.delete();
      vec_ready = 1'b1;
      @(posedge clk); #1;
      check("t6_still_idle", 32'(vec_valid), 32'd0);

      // Mask with only ignored bits set.
      send_mask(32'hFFFF_FC00, 16'h1234);
      check("t7_err_pulse", 32'(empty_err), 32'd1);
      check("t7_no_beat", 32'(vec_valid), 32'd0);
      check("t7_ready", 32'(cls_ready), 32'd1);
      @(posedge clk); #1;
      check("t7_err_single", 32'(empty_err), 32'd0);

      // Flush coinciding with an empty mask suppresses the error.
      flush = 1'b1;
      send_mask(32'h0000_0000, 16'h0000);
      flush = 1'b0;
      check("t7b_err_suppressed", 32'(empty_err), 32'd0);

      // Asynchronous reset in the middle of a stalled stream.
      vec_ready = 1'b0;
      push_table(10'h3FF);
      send_mask(32'h0000_03FF, 16'h3C01);
      @(posedge clk); #2;
      rst_l = 1'b0;
      #1;
      check_reset_outputs("t8_async");
      sb_q.delete();
      @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk); #1;

      // Recovery after reset.
      vec_ready = 1'b1;
      push(16'hFC00, CLS_NEG_INF, 1'b0);
      push(16'h7C00, CLS_POS_INF, 1'b1);
      send_mask(32'h0000_0081, 16'h0000);
      drain("t9");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_fclass_vecgen.md
Name: fpu_fclass_vecgen

Overview:
Inverse of the FPU classifier: accepts a class mask in fclass result format and emits, one per cycle, a representative floating-point operand for each set class bit.
- Used in the FPU self-test and verification path to generate operands that classify back to the requested classes.
- Also supplies canonical special values (±inf, ±0, qNaN) to the FPU datapath.
- Valid/ready handshakes on both sides; one mask in, a stream of operands out.

Parameters:
Std, 15, index of sign bit (operand width − 1).
Man, 9, index of mantissa MSB (quiet bit); exponent field is [Std-1:Man+1].

Ports:
clk  input  1  clock.
rst_l  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort; highest priority after reset.
cls_valid  input  1  mask offered.
cls_ready  output  1  mask accepted when cls_valid & cls_ready.
cls_mask  input  32  fclass-format mask; bits 31:10 ignored.
seed  input  Std+1  operand seed, sampled with the mask.
vec_valid  output  1  operand available.
vec_ready  input  1  consumer accepts operand.
vec_data  output  Std+1  generated operand.
vec_class  output  4  class bit index (0..9) of vec_data.
vec_last  output  1  vec_data is the final operand for this mask.
empty_err  output  1  one-cycle pulse: accepted mask had bits 9:0 all zero.

Behaviour:
- Class bit map: 0 −inf, 1 −normal, 2 −subnormal, 3 −zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- Emit order: ascending bit index.
- Value rules (E = exponent field, M = mantissa field, S = seed fields):
  - ±inf: E all ones, M = 0.
  - ±zero: E = 0, M = 0.
  - ±normal: E = S.E, except 0→1 and all-ones→all-ones−1; M = S.M.
  - ±subnormal: E = 0, M = S.M, except 0→1.
  - sNaN: sign 0, E all ones, M[Man] = 0, M[Man-1:0] = S.M[Man-1:0], except 0→1.
  - qNaN: sign 0, E all ones, M = 1<<Man (canonical).
- States: IDLE, EMIT.
- IDLE:
  - cls_ready = 1.
  - On accept with mask[9:0] ≠ 0: latch the mask into rem_mask and the seed into a register; go to EMIT.
  - On accept with mask[9:0] = 0: empty_err = 1 the next cycle; stay in IDLE.
- EMIT:
  - cls_ready = 0; vec_valid = 1.
  - vec_class = lowest set bit of rem_mask; vec_data = value for that class using the latched seed.
  - vec_last = 1 when exactly one bit of rem_mask is set.
  - On vec_ready: clear that bit. If vec_last, go to IDLE; otherwise stay in EMIT.
  - vec_valid low with vec_ready high: no effect.
- Output stability: while vec_valid & ~vec_ready, vec_data, vec_class and vec_last are held.
- Latency:
  - Mask accepted at edge N → first vec_valid in cycle N+1.
  - With vec_ready held high, a k-bit mask produces k consecutive beats.
  - cls_ready returns the cycle after the last beat, so there is one bubble between masks.
- flush: state→IDLE, rem_mask←0, vec_valid deasserted next cycle; any pending empty_err is suppressed.
- Reset (asynchronous, rst_l = 0): state IDLE, rem_mask 0, seed register 0.
  - Outputs during/after reset: cls_ready 1, vec_valid 0, vec_data 0, vec_class 0, vec_last 0, empty_err 0.
  - Reset mid-stream drops the remaining operands.
- Outputs are registered or derived only from registered state; no combinational path from vec_ready to vec_valid or vec_data.

Decomposition:
- Shared package: class bit index constants (CLS_NEG_INF … CLS_QNAN); localparams for exponent width (Std−Man−1) and mantissa width (Man+1); the all-ones exponent constant.
- One combinational sub-module, fpu_class_value (inputs class index and seed; output operand), holding the value rules above.
- Top level holds the FSM, rem_mask, the lowest-set-bit priority encoder and the handshakes.

Test Plan:
- Reset, then mask 0x0000_0081, seed 0, vec_ready = 1 → beats 0xFC00 (class 0), 0x7C00 (class 7, vec_last = 1); cls_ready high again on the following cycle.
- Mask 0x0000_0218, seed 0 → 0x8000 (class 3), 0x0000 (class 4), 0x7E00 (class 9, last).
- Mask 0x0000_0166, seed 0x3C01 → 0xBC01, 0x8001, 0x0001, 0x3C01, 0x7C01.
- Seed boundaries, mask 0x0000_0160:
  - seed 0x0000 → 0x0001, 0x0400, 0x7C01.
  - seed 0x7FFF → 0x03FF, 0x7BFF, 0x7DFF.
- Mask 0x3FF, vec_ready toggled randomly → 10 beats in ascending class order; data stable while stalled; vec_last only on class 9.
- Abort and error paths:
  - flush on the 3rd beat → vec_valid low next cycle, cls_ready high.
  - mask 0xFFFF_FC00 → no beats; empty_err pulses once.
  - rst_l low mid-stream → all outputs reach their reset values immediately (asynchronous).
